// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs loads/stores over a req/ack memory port, passes ALU
// results through, and stalls the EX-to-MEM register while an access is in flight.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 3,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               op_valid,
  input  logic               load_in,
  input  logic               store_in,
  input  logic [ADDR_W-1:0]  mem_addr_in,
  input  logic [RADDR_W-1:0] rdest_addr_in,
  input  logic [DATA_W-1:0]  rdest_data_in,
  output logic               EXtoMEM_Wen,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               wb_valid,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               mem_err
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_wb_valid;
  logic               r_wb_we;
  logic [RADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0]  r_wb_data;
  logic               r_mem_err;

  logic w_mem_op;
  logic w_timeout;
  logic w_wen;

  assign w_mem_op  = op_valid & (load_in | store_in);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Wen reopens in the ack/abort cycle itself so the next op loads on that edge.
  always_comb begin
    w_wen = 1'b1;
    if (r_state == S_IDLE) begin
      w_wen = ~w_mem_op;
    end else begin
      w_wen = mem_ack | w_timeout;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_mem_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_state     <= S_ACCESS;
            r_mem_req   <= 1'b1;
            r_mem_we    <= store_in;
            r_mem_addr  <= mem_addr_in;
            r_mem_wdata <= rdest_data_in;
            r_cnt       <= '0;
          end else if (op_valid) begin
            r_wb_valid <= 1'b1;
            r_wb_we    <= 1'b1;
            r_wb_addr  <= rdest_addr_in;
            r_wb_data  <= rdest_data_in;
          end
        end
        S_ACCESS: begin
          // An ack in the final timeout cycle still completes the access.
          if (mem_ack) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_addr  <= rdest_addr_in;
            r_wb_we    <= ~r_mem_we;
            r_wb_data  <= r_mem_we ? '0 : mem_rdata;
          end else if (w_timeout) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_err  <= 1'b1;
            r_wb_valid <= 1'b1;
            r_wb_we    <= 1'b0;
            r_wb_addr  <= rdest_addr_in;
            r_wb_data  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign EXtoMEM_Wen = w_wen;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign wb_valid    = r_wb_valid;
  assign wb_we       = r_wb_we;
  assign wb_addr     = r_wb_addr;
  assign wb_data     = r_wb_data;
  assign mem_err     = r_mem_err;

endmodule
